// File: rtl/led_pwm_driver.sv
// LED PWM output stage: shadow duties via valid/ready, committed to the active set at the frame boundary; o_led 1-cycle latency.
// Ready drops only in the commit cycle. Define LED_PWM_STAGGER_EN to offset channel k's phase by k*(PERIOD/CHANNELS).
module led_pwm_driver #(
    parameter int  CHANNELS = 4,
    parameter int  DUTY_W   = 8,
    parameter int  PRESCALE = 256,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_duty_valid,
    output logic                o_duty_ready,
    input  logic [CH_W-1:0]     i_duty_ch,
    input  logic [DUTY_W-1:0]   i_duty,
    output logic                o_frame_start,
    output logic [CHANNELS-1:0] o_led
);
    localparam int PERIOD = (1 << DUTY_W) - 1;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SUM_W  = DUTY_W + 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);

    logic [PS_W-1:0]     presc;
    logic [PS_W-1:0]     presc_nxt;
    logic [DUTY_W-1:0]   cnt;
    logic [DUTY_W-1:0]   cnt_nxt;
    logic                tick;
    logic                commit;
    logic                commit_ahead;
    logic                wr_en;
    logic [DUTY_W-1:0]   shadow [CHANNELS];
    logic [DUTY_W-1:0]   active [CHANNELS];
    logic [DUTY_W-1:0]   phase  [CHANNELS];
    logic [CHANNELS-1:0] led_nxt;

    assign tick      = (presc == PS_LAST);
    assign commit    = tick && (cnt == CNT_LAST);
    assign presc_nxt = tick ? '0 : presc + PS_W'(1);
    assign cnt_nxt   = commit ? '0 : (tick ? cnt + DUTY_W'(1) : cnt);
    assign wr_en     = i_duty_valid && o_duty_ready;

    // Ready is registered, so predict whether the coming cycle is the commit cycle.
    assign commit_ahead = (presc_nxt == PS_LAST) && (cnt_nxt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc         <= '0;
            cnt           <= '0;
            o_duty_ready  <= 1'b0;
            o_frame_start <= 1'b0;
            o_led         <= '0;
        end else begin
            presc         <= presc_nxt;
            cnt           <= cnt_nxt;
            o_duty_ready  <= !commit_ahead;
            o_frame_start <= commit;
            o_led         <= led_nxt;
        end
    end

    // Writes cannot coincide with a commit since ready is low then; out-of-range channels match no slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_en && (i_duty_ch == CH_W'(k)))
                    shadow[k] <= i_duty;
                if (commit)
                    active[k] <= shadow[k];
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
`ifdef LED_PWM_STAGGER_EN
        localparam logic [SUM_W-1:0] OFF = SUM_W'(k * (PERIOD / CHANNELS));
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] wrapped;
        assign sum      = {1'b0, cnt} + OFF;
        assign wrapped  = sum - SUM_W'(PERIOD);
        assign phase[k] = (sum >= SUM_W'(PERIOD)) ? wrapped[DUTY_W-1:0] : sum[DUTY_W-1:0];
`else
        assign phase[k] = cnt;
`endif
        // cnt never reaches PERIOD, so duty PERIOD stays on through the wrap.
        assign led_nxt[k] = (phase[k] < active[k]);
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with DUTY_W=4 (PERIOD=15), PRESCALE=2, CHANNELS=4: 30-clock frames.
module tb_led_pwm_driver;
    localparam int CH = 4;
    localparam int DW = 4;
    localparam int PS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          duty_valid = 1'b0;
    logic          duty_ready;
    logic [1:0]    duty_ch = '0;
    logic [DW-1:0] duty = '0;
    logic          frame_start;
    logic [CH-1:0] led;

    int errors = 0;
    int checks = 0;
    int dexp [CH];

    always #5 clk = ~clk;

    led_pwm_driver #(.CHANNELS(CH), .DUTY_W(DW), .PRESCALE(PS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_duty_valid (duty_valid),
        .o_duty_ready (duty_ready),
        .i_duty_ch    (duty_ch),
        .i_duty       (duty),
        .o_frame_start(frame_start),
        .o_led        (led)
    );

    // j counts clocks from an o_frame_start cycle (j=0); the LED is high for 2*d clocks starting at j=1.
    function automatic bit pwm_exp(input int d, input int j);
        int jj;
        jj = j % 30;
        if (d == 15) return 1'b1;
        return (jj >= 1) && (jj <= 2 * d);
    endfunction

    function automatic bit stag_exp(input int k, input int d, input int j);
        int jj, c, ph;
        jj = j % 30;
        c  = (jj == 0) ? 14 : (jj - 1) / 2;
        ph = (c + k * 3) % 15;
        return ph < d;
    endfunction

    task automatic write_duty(input int ch, input int d);
        int n = 0;
        duty_valid = 1'b1;
        duty_ch    = 2'(ch);
        duty       = DW'(d);
        while (duty_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_accept: ready=%b after %0d cycles, want 1", duty_ready, n);
        end
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame_start=%b after %0d cycles, want 1", frame_start, n);
        end
    endtask

    task automatic test_reset();
        int fs_at = -1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (led !== 4'b0000 || duty_ready !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: led=%b ready=%b fs=%b, want 0000 0 0", led, duty_ready, frame_start);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (duty_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_release: ready=%b, want 1", duty_ready);
                end
            end
            if (k == 29) begin
                checks++;
                if (duty_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_commit_cycle: ready=%b, want 0", duty_ready);
                end
            end
            if (frame_start === 1'b1) begin
                fs_at = k;
                break;
            end
        end
        checks++;
        if (fs_at != 30) begin
            errors++;
            $display("FAIL first_frame_start: at clock %0d, want 30", fs_at);
        end
    endtask

    task automatic test_deferred_commit();
        int k;
        repeat (14) @(negedge clk);
        write_duty(0, 5);
        k = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
            checks++;
            if (led[0] !== 1'b0) begin
                errors++;
                $display("FAIL deferred_mid_frame: led0=%b at +%0d, want 0", led[0], k);
            end
        end
        checks++;
        if (k != 15) begin
            errors++;
            $display("FAIL deferred_frame_pos: frame start %0d clocks after write, want 15", k);
        end
        dexp[0] = 5;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            checks++;
            if (led[0] !== pwm_exp(5, j)) begin
                errors++;
                $display("FAIL deferred_pwm: j=%0d led0=%b, want %b", j, led[0], pwm_exp(5, j));
            end
        end
    endtask

    task automatic test_back_to_back_extremes();
        write_duty(1, 9);
        write_duty(1, 0);
        write_duty(2, 15);
        wait_frame();
        dexp[1] = 0;
        dexp[2] = 15;
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            for (int k = 0; k < CH; k++) begin
                checks++;
                if (led[k] !== pwm_exp(dexp[k], j)) begin
                    errors++;
                    $display("FAIL extremes: j=%0d ch%0d led=%b, want %b", j, k, led[k], pwm_exp(dexp[k], j));
                end
            end
        end
    endtask

    task automatic test_commit_collision();
        bit e;
        repeat (29) @(negedge clk);
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready_low: ready=%b, want 0", duty_ready);
        end
        duty_valid = 1'b1;
        duty_ch    = 2'd3;
        duty       = 4'd8;
        @(negedge clk);
        checks++;
        if (duty_ready !== 1'b1 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL collision_next: ready=%b fs=%b, want 1 1", duty_ready, frame_start);
        end
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            if (j == 1) duty_valid = 1'b0;
            for (int k = 0; k < CH; k++) begin
                if (k == 3) e = (j < 30) ? 1'b0 : pwm_exp(8, j);
                else        e = pwm_exp(dexp[k], j);
                checks++;
                if (led[k] !== e) begin
                    errors++;
                    $display("FAIL collision_pwm: j=%0d ch%0d led=%b, want %b", j, k, led[k], e);
                end
            end
        end
        dexp[3] = 8;
    endtask

    task automatic test_async_reset();
        write_duty(0, 8);
        wait_frame();
        repeat (6) @(negedge clk);
        checks++;
        if (led[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_led0: led0=%b, want 1", led[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0000 || duty_ready !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: led=%b ready=%b fs=%b, want 0000 0 0", led, duty_ready, frame_start);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < CH; k++) dexp[k] = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            checks++;
            if (led !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_led: +%0d led=%b, want 0000", k, led);
            end
            if (k == 30) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL post_reset_frame: fs=%b at clock 30, want 1", frame_start);
                end
            end
        end
    endtask

`ifdef LED_PWM_STAGGER_EN
    task automatic test_stagger();
        int highs [CH];
        for (int k = 0; k < CH; k++) highs[k] = 0;
        for (int k = 0; k < CH; k++) write_duty(k, 7);
        wait_frame();
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            for (int k = 0; k < CH; k++) begin
                if (j <= 30 && led[k] === 1'b1) highs[k]++;
                checks++;
                if (led[k] !== stag_exp(k, 7, j)) begin
                    errors++;
                    $display("FAIL stagger: j=%0d ch%0d led=%b, want %b", j, k, led[k], stag_exp(k, 7, j));
                end
            end
        end
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (highs[k] != 14) begin
                errors++;
                $display("FAIL stagger_high: ch%0d high %0d clocks, want 14", k, highs[k]);
            end
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < CH; k++) dexp[k] = 0;
        test_reset();
        test_deferred_commit();
        test_back_to_back_extremes();
        test_commit_collision();
        test_async_reset();
`ifdef LED_PWM_STAGGER_EN
        test_stagger();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
